// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch front end for the 16-bit CPU.
// Owns the PC, issues single-outstanding word reads over req/gnt/rvalid,
// buffers returned words in a small prefetch FIFO and presents the head to
// the decoder through registered dec_* outputs. A redirect flushes the FIFO
// and discards any in-flight response.
// Optional build macro IFU_PERF_CNT_EN adds the perf_starve / perf_flush
// saturating counters and their output ports.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       DATA_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dec_valid,
  output logic [DATA_W-1:0] dec_instr,
  output logic [ADDR_W-1:0] dec_pc,
  input  logic              dec_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [15:0]       perf_starve,
  output logic [15:0]       perf_flush
`endif
);

  localparam int unsigned      PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned      CNT_W    = $clog2(BUF_DEPTH + 1);
  localparam int unsigned      ENT_W    = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic [ADDR_W-1:0]  r_req_pc;
  logic               r_mem_req;
  logic               w_mem_req_nxt;

  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   w_rd_ptr_inc;
  logic [PTR_W-1:0]   w_wr_ptr_inc;
  logic [ENT_W-1:0]   r_buf [BUF_DEPTH];

  logic               w_grant;
  logic               w_push;
  logic               w_pop;
  logic [ENT_W-1:0]   w_push_data;
  logic               w_head_load;
  logic [ENT_W-1:0]   w_head_data;
  logic [DATA_W-1:0]  r_dec_instr;
  logic [ADDR_W-1:0]  r_dec_pc;

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_pc;
  assign dec_valid = (r_count != '0);
  assign dec_instr = r_dec_instr;
  assign dec_pc    = r_dec_pc;

  assign w_grant     = (r_state == S_REQ) && r_mem_req && mem_gnt;
  assign w_pop       = dec_valid && dec_ready;
  assign w_push      = (r_state == S_WAIT) && mem_rvalid && !redirect;
  assign w_push_data = {r_req_pc, mem_rdata};

  assign w_rd_ptr_inc = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
  assign w_wr_ptr_inc = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);

  // Next-state, next-PC and registered request decision for the fetch FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    unique case (r_state)
      S_REQ: begin
        if (redirect) begin
          w_pc_nxt = redirect_pc;
          if (w_grant) begin
            w_state_nxt = S_DROP;
          end
        end else if (w_grant) begin
          w_pc_nxt    = r_pc + ADDR_W'(1);
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response landing in the redirect cycle is already complete, so
        // it is dropped here rather than waiting in DROP for a second one.
        if (redirect) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = mem_rvalid ? S_REQ : S_DROP;
        end else if (mem_rvalid) begin
          w_state_nxt = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect) begin
          w_pc_nxt = redirect_pc;
        end
        if (mem_rvalid) begin
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase

    w_count_nxt = r_count;
    if (redirect) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end

    // Issue is gated on FIFO space; a redirect in REQ leaves one idle cycle.
    w_mem_req_nxt = (w_state_nxt == S_REQ) && (w_count_nxt < DEPTH_C) && !redirect;
  end

  // Selects the value the registered head must take after this cycle.
  always_comb begin
    w_head_load = 1'b0;
    w_head_data = r_buf[w_rd_ptr_inc];
    if (!redirect) begin
      if (w_pop) begin
        if (r_count > CNT_W'(1)) begin
          w_head_load = 1'b1;
        end else if (w_push) begin
          w_head_load = 1'b1;
          w_head_data = w_push_data;
        end
      end else if ((r_count == '0) && w_push) begin
        w_head_load = 1'b1;
        w_head_data = w_push_data;
      end
    end
  end

  // FSM state, program counter and memory request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_REQ;
      r_pc      <= RESET_PC;
      r_req_pc  <= RESET_PC;
      r_mem_req <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_mem_req <= w_mem_req_nxt;
      if (w_grant) begin
        r_req_pc <= r_pc;
      end
    end
  end

  // FIFO occupancy and circular pointers; a redirect empties the buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (redirect) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      if (w_push) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
    end
  end

  // FIFO storage; the head entry is mirrored into the dec_* registers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf[r_wr_ptr] <= w_push_data;
    end
  end

  // Registered decoder outputs; they hold their last value when empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dec_instr <= '0;
      r_dec_pc    <= '0;
    end else if (w_head_load) begin
      r_dec_instr <= w_head_data[DATA_W-1:0];
      r_dec_pc    <= w_head_data[ENT_W-1:DATA_W];
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [15:0] r_perf_starve;
  logic [15:0] r_perf_flush;

  assign perf_starve = r_perf_starve;
  assign perf_flush  = r_perf_flush;

  // Saturating counters: decoder starvation cycles and redirect pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_starve <= '0;
      r_perf_flush  <= '0;
    end else begin
      if (dec_ready && !dec_valid && (r_perf_starve != '1)) begin
        r_perf_starve <= r_perf_starve + 16'd1;
      end
      if (redirect && (r_perf_flush != '1)) begin
        r_perf_flush <= r_perf_flush + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: a behavioural instruction memory answers
// requests with a configurable grant rate and response latency; the expected
// decoder stream is a sequential address run that restarts at each redirect
// target, with instruction words given by a fixed function of address.
module tb_instr_fetch_unit;

  localparam logic [15:0] RST_PC = 16'h0010;
  localparam int unsigned DEPTH  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        dec_valid;
  logic [15:0] dec_instr;
  logic [15:0] dec_pc;
  logic        dec_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
`ifdef IFU_PERF_CNT_EN
  logic [15:0] perf_starve;
  logic [15:0] perf_flush;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .RESET_PC (RST_PC),
    .BUF_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .dec_valid  (dec_valid),
    .dec_instr  (dec_instr),
    .dec_pc     (dec_pc),
    .dec_ready  (dec_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_starve(perf_starve),
    .perf_flush (perf_flush)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // sampled DUT outputs for the current cycle
  logic        s_req, s_valid;
  logic [15:0] s_addr, s_instr, s_pc;

  // memory model state
  logic        pend;
  int          pend_cnt;
  logic [15:0] pend_addr;
  int          lat_min, lat_max, gnt_pct;
  logic        d_gnt;

  // perf model
  int m_starve, m_flush;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] k;
    k = 16'h9E37;
    return (a * k) ^ 16'h5A5A;
  endfunction

  task automatic tick_sample();
    @(negedge clk);
    s_req   = mem_req;
    s_addr  = mem_addr;
    s_valid = dec_valid;
    s_instr = dec_instr;
    s_pc    = dec_pc;
  endtask

  task automatic tick_drive(input logic rdy, input logic redir, input logic [15:0] rpc);
    mem_rvalid = 1'b0;
    mem_rdata  = 16'($urandom);
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(pend_addr);
        pend       = 1'b0;
      end
    end
    d_gnt   = s_req && !pend && ($urandom_range(99, 0) < gnt_pct);
    mem_gnt = d_gnt;
    if (d_gnt) begin
      pend      = 1'b1;
      pend_cnt  = int'($urandom_range(lat_max, lat_min));
      pend_addr = s_addr;
    end
    dec_ready   = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    if (rdy && !s_valid) m_starve++;
    if (redir) m_flush++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset      = 1'b1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    dec_ready  = 1'b0;
    redirect   = 1'b0;
    pend       = 1'b0;
    m_starve   = 0;
    m_flush    = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] exp_pc;
    int ng, n_pop, t_g, t_v;
    @(negedge clk);
    #1;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b expected 0", mem_req); else n_pass++;
    n_checks++; if (mem_addr !== RST_PC) $display("FAIL rst_mem_addr: got %h expected %h", mem_addr, RST_PC); else n_pass++;
    n_checks++; if (dec_valid !== 1'b0) $display("FAIL rst_dec_valid: got %b expected 0", dec_valid); else n_pass++;
    n_checks++; if (dec_instr !== 16'h0) $display("FAIL rst_dec_instr: got %h expected 0000", dec_instr); else n_pass++;
    n_checks++; if (dec_pc !== 16'h0) $display("FAIL rst_dec_pc: got %h expected 0000", dec_pc); else n_pass++;
    apply_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    exp_pc = RST_PC; ng = 0; n_pop = 0; t_g = -1; t_v = -1;
    for (int t = 0; t < 40 && n_pop < 3; t++) begin
      tick_sample();
      if (s_valid && t_v < 0) t_v = t;
      tick_drive(1'b1, 1'b0, 16'h0);
      if (d_gnt) begin
        if (ng == 0) t_g = t;
        if (ng < 3) begin
          n_checks++;
          if (s_addr !== RST_PC + 16'(ng)) $display("FAIL seq_mem_addr: got %h expected %h", s_addr, RST_PC + 16'(ng)); else n_pass++;
        end
        ng++;
      end
      if (s_valid) begin
        n_checks++; if (s_pc !== exp_pc) $display("FAIL seq_dec_pc: got %h expected %h", s_pc, exp_pc); else n_pass++;
        n_checks++; if (s_instr !== mem_word(exp_pc)) $display("FAIL seq_dec_instr: got %h expected %h", s_instr, mem_word(exp_pc)); else n_pass++;
        exp_pc = exp_pc + 16'd1;
        n_pop++;
      end
    end
    n_checks++; if (n_pop !== 3) $display("FAIL seq_pop_count: got %0d expected 3", n_pop); else n_pass++;
    n_checks++; if ((t_v - t_g) !== 2) $display("FAIL first_valid_latency: got %0d expected 2", t_v - t_g); else n_pass++;
  endtask

  task automatic test_fill_drain();
    logic [15:0] exp_pc, first_addr;
    int ng, n_pop;
    logic got_first;
    apply_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    ng = 0;
    for (int t = 0; t < 12; t++) begin
      tick_sample();
      tick_drive(1'b0, 1'b0, 16'h0);
      if (d_gnt) ng++;
    end
    n_checks++; if (ng !== int'(DEPTH)) $display("FAIL fill_grants: got %0d expected %0d", ng, DEPTH); else n_pass++;
    exp_pc = RST_PC; n_pop = 0; got_first = 1'b0; first_addr = 16'h0;
    for (int t = 0; t < 30 && n_pop < 3; t++) begin
      tick_sample();
      if (t == 0) begin
        n_checks++; if (s_valid !== 1'b1) $display("FAIL full_dec_valid: got %b expected 1", s_valid); else n_pass++;
        n_checks++; if (s_req !== 1'b0) $display("FAIL full_mem_req: got %b expected 0", s_req); else n_pass++;
      end
      tick_drive(1'b1, 1'b0, 16'h0);
      if (d_gnt && !got_first) begin
        got_first  = 1'b1;
        first_addr = s_addr;
      end
      if (s_valid) begin
        n_checks++; if (s_pc !== exp_pc) $display("FAIL drain_dec_pc: got %h expected %h", s_pc, exp_pc); else n_pass++;
        n_checks++; if (s_instr !== mem_word(exp_pc)) $display("FAIL drain_dec_instr: got %h expected %h", s_instr, mem_word(exp_pc)); else n_pass++;
        exp_pc = exp_pc + 16'd1;
        n_pop++;
      end
    end
    n_checks++; if (first_addr !== 16'h0012) $display("FAIL resume_addr: got %h expected 0012", first_addr); else n_pass++;
    n_checks++; if (n_pop !== 3) $display("FAIL drain_pop_count: got %0d expected 3", n_pop); else n_pass++;
  endtask

  task automatic test_redirect_wait();
    logic [15:0] exp_pc, gaddr;
    logic done, redir, prev_redir, got_g, got_p;
    apply_reset();
    gnt_pct = 100; lat_min = 3; lat_max = 3;
    exp_pc = RST_PC; done = 1'b0; prev_redir = 1'b0; got_g = 1'b0; got_p = 1'b0; gaddr = 16'h0;
    for (int t = 0; t < 80 && !got_p; t++) begin
      tick_sample();
      if (prev_redir) begin
        n_checks++; if (s_valid !== 1'b0) $display("FAIL rw_flush_valid: got %b expected 0", s_valid); else n_pass++;
      end
      redir = !done && pend && (pend_addr == 16'h0013);
      tick_drive(1'b1, redir, 16'h0200);
      if (d_gnt && done && !got_g) begin
        got_g = 1'b1;
        gaddr = s_addr;
      end
      if (s_valid) begin
        n_checks++; if (s_pc !== exp_pc) $display("FAIL rw_dec_pc: got %h expected %h", s_pc, exp_pc); else n_pass++;
        n_checks++; if (s_instr !== mem_word(exp_pc)) $display("FAIL rw_dec_instr: got %h expected %h", s_instr, mem_word(exp_pc)); else n_pass++;
        if (done) got_p = 1'b1;
        exp_pc = exp_pc + 16'd1;
      end
      if (redir) begin
        done   = 1'b1;
        exp_pc = 16'h0200;
      end
      prev_redir = redir;
    end
    n_checks++; if (gaddr !== 16'h0200) $display("FAIL rw_next_addr: got %h expected 0200", gaddr); else n_pass++;
    n_checks++; if (got_p !== 1'b1) $display("FAIL rw_timeout: got %b expected 1", got_p); else n_pass++;
  endtask

  task automatic test_redirect_grant();
    logic [15:0] exp_pc, rpc, gaddr;
    logic redir, prev_redir, done, got_g, got_p;
    apply_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    exp_pc = RST_PC; prev_redir = 1'b0; done = 1'b0; got_g = 1'b0; got_p = 1'b0; gaddr = 16'h0;
    for (int t = 0; t < 80 && !got_p; t++) begin
      tick_sample();
      if (prev_redir && done) begin
        n_checks++; if (s_valid !== 1'b0) $display("FAIL rg_flush_valid: got %b expected 0", s_valid); else n_pass++;
      end
      redir = 1'b0; rpc = 16'h0;
      if (t == 0) begin
        redir = 1'b1; rpc = 16'h0004;
      end else if (!done && s_req && s_addr == 16'h0005) begin
        redir = 1'b1; rpc = 16'h0300; lat_min = 3; lat_max = 3;
      end
      tick_drive(1'b1, redir, rpc);
      lat_min = 1; lat_max = 1;
      if (d_gnt && done && !got_g) begin
        got_g = 1'b1;
        gaddr = s_addr;
      end
      if (s_valid) begin
        n_checks++; if (s_pc !== exp_pc) $display("FAIL rg_dec_pc: got %h expected %h", s_pc, exp_pc); else n_pass++;
        n_checks++; if (s_instr !== mem_word(exp_pc)) $display("FAIL rg_dec_instr: got %h expected %h", s_instr, mem_word(exp_pc)); else n_pass++;
        if (done) got_p = 1'b1;
        exp_pc = exp_pc + 16'd1;
      end
      if (redir) begin
        exp_pc = rpc;
        if (rpc == 16'h0300) done = 1'b1;
      end
      prev_redir = redir;
    end
    n_checks++; if (gaddr !== 16'h0300) $display("FAIL rg_next_addr: got %h expected 0300", gaddr); else n_pass++;
    n_checks++; if (got_p !== 1'b1) $display("FAIL rg_timeout: got %b expected 1", got_p); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [15:0] exp_pc;
    logic saw_ffff, checked;
    int n_pop;
    apply_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    exp_pc = RST_PC; saw_ffff = 1'b0; checked = 1'b0; n_pop = 0;
    for (int t = 0; t < 60 && n_pop < 3; t++) begin
      tick_sample();
      tick_drive(1'b1, t == 0, 16'hFFFE);
      if (d_gnt && saw_ffff && !checked) begin
        checked = 1'b1;
        n_checks++; if (s_addr !== 16'h0000) $display("FAIL wrap_addr: got %h expected 0000", s_addr); else n_pass++;
      end
      if (d_gnt && s_addr == 16'hFFFF) saw_ffff = 1'b1;
      if (s_valid) begin
        n_checks++; if (s_pc !== exp_pc) $display("FAIL wrap_dec_pc: got %h expected %h", s_pc, exp_pc); else n_pass++;
        n_checks++; if (s_instr !== mem_word(exp_pc)) $display("FAIL wrap_dec_instr: got %h expected %h", s_instr, mem_word(exp_pc)); else n_pass++;
        exp_pc = exp_pc + 16'd1;
        n_pop++;
      end
      if (t == 0) exp_pc = 16'hFFFE;
    end
    n_checks++; if (checked !== 1'b1) $display("FAIL wrap_timeout: got %b expected 1", checked); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] gaddr;
    logic got_g, hit;
    int n_pop;
    apply_reset();
    gnt_pct = 100; lat_min = 3; lat_max = 3;
    n_pop = 0; hit = 1'b0;
    for (int t = 0; t < 60 && !hit; t++) begin
      tick_sample();
      if (n_pop >= 2 && pend) begin
        hit = 1'b1;
      end else begin
        tick_drive(1'b1, 1'b0, 16'h0);
        if (s_valid) n_pop++;
      end
    end
    n_checks++; if (hit !== 1'b1) $display("FAIL mid_reach_wait: got %b expected 1", hit); else n_pass++;
    reset = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0; pend = 1'b0;
    #1;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL mid_mem_req: got %b expected 0", mem_req); else n_pass++;
    n_checks++; if (mem_addr !== RST_PC) $display("FAIL mid_mem_addr: got %h expected %h", mem_addr, RST_PC); else n_pass++;
    n_checks++; if (dec_valid !== 1'b0) $display("FAIL mid_dec_valid: got %b expected 0", dec_valid); else n_pass++;
    n_checks++; if (dec_instr !== 16'h0) $display("FAIL mid_dec_instr: got %h expected 0000", dec_instr); else n_pass++;
    n_checks++; if (dec_pc !== 16'h0) $display("FAIL mid_dec_pc: got %h expected 0000", dec_pc); else n_pass++;
    apply_reset();
    lat_min = 1; lat_max = 1;
    got_g = 1'b0; gaddr = 16'h0;
    for (int t = 0; t < 10 && !got_g; t++) begin
      tick_sample();
      tick_drive(1'b1, 1'b0, 16'h0);
      if (d_gnt) begin
        got_g = 1'b1;
        gaddr = s_addr;
      end
    end
    n_checks++; if (gaddr !== RST_PC) $display("FAIL mid_first_addr: got %h expected %h", gaddr, RST_PC); else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] exp_pc, rpc, prev_addr;
    logic rdy, redir, prev_req, prev_gnt, prev_redir;
    int n_pop;
    apply_reset();
    gnt_pct = 60; lat_min = 1; lat_max = 4;
    exp_pc = RST_PC; prev_req = 1'b0; prev_gnt = 1'b0; prev_redir = 1'b0; prev_addr = 16'h0; n_pop = 0;
    for (int t = 0; t < 3000; t++) begin
      tick_sample();
      n_checks++; if ((s_req && pend) !== 1'b0) $display("FAIL rand_outstanding: got req=%b pend=%b expected no request", s_req, pend); else n_pass++;
      if (prev_req && !prev_gnt && !prev_redir) begin
        n_checks++;
        if ({s_req, s_addr} !== {1'b1, prev_addr}) $display("FAIL rand_req_stable: got %b/%h expected 1/%h", s_req, s_addr, prev_addr); else n_pass++;
      end
      if (prev_redir) begin
        n_checks++; if (s_valid !== 1'b0) $display("FAIL rand_flush_valid: got %b expected 0", s_valid); else n_pass++;
      end
      rdy   = ($urandom_range(99, 0) < 70);
      redir = ($urandom_range(99, 0) < 4);
      rpc   = 16'($urandom);
      tick_drive(rdy, redir, rpc);
      if (s_valid && rdy) begin
        n_checks++; if (s_pc !== exp_pc) $display("FAIL rand_dec_pc: got %h expected %h", s_pc, exp_pc); else n_pass++;
        n_checks++; if (s_instr !== mem_word(exp_pc)) $display("FAIL rand_dec_instr: got %h expected %h", s_instr, mem_word(exp_pc)); else n_pass++;
        exp_pc = exp_pc + 16'd1;
        n_pop++;
      end
      if (redir) exp_pc = rpc;
      prev_req = s_req; prev_addr = s_addr; prev_gnt = d_gnt; prev_redir = redir;
    end
    n_checks++; if (n_pop < 100) $display("FAIL rand_progress: got %0d pops expected at least 100", n_pop); else n_pass++;
  endtask

`ifdef IFU_PERF_CNT_EN
  task automatic test_perf();
    apply_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 2;
    for (int t = 0; t < 40; t++) begin
      tick_sample();
      tick_drive(1'b1, (t % 5 == 4) && (t < 25), 16'($urandom));
    end
    tick_sample();
    n_checks++; if (perf_flush !== 16'd5) $display("FAIL perf_flush: got %0d expected 5", perf_flush); else n_pass++;
    n_checks++; if (perf_starve !== 16'(m_starve)) $display("FAIL perf_starve: got %0d expected %0d", perf_starve, m_starve); else n_pass++;
    tick_drive(1'b0, 1'b0, 16'h0);
  endtask
`endif

  initial begin
    reset = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'h0;
    dec_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    pend = 1'b0; pend_cnt = 0; pend_addr = 16'h0; d_gnt = 1'b0;
    lat_min = 1; lat_max = 1; gnt_pct = 100; m_starve = 0; m_flush = 0;
    test_reset();
    test_fill_drain();
    test_redirect_wait();
    test_redirect_grant();
    test_wrap();
    test_reset_mid();
    test_random();
`ifdef IFU_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch front end for the 16-bit CPU. It owns the program counter and issues word reads to instruction memory over a request/grant/rvalid handshake. Returned instructions are buffered in a small prefetch FIFO and presented to the decoder/IR stage with a valid/ready handshake. A branch redirect flushes the buffer and any in-flight fetch.

Parameters:
ADDR_W, 16, instruction memory word-address width.
DATA_W, 16, instruction width.
RESET_PC, 0, PC value loaded on reset.
BUF_DEPTH, 2, prefetch FIFO entries; legal range 2..8.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
mem_req  out  1  read request to instruction memory
mem_addr  out  ADDR_W  word address of request
mem_gnt  in  1  memory accepts the request this cycle
mem_rvalid  in  1  read data valid; arrives at least 1 cycle after grant
mem_rdata  in  DATA_W  instruction word
dec_valid  out  1  FIFO head is valid for the decoder
dec_instr  out  DATA_W  instruction at FIFO head
dec_pc  out  ADDR_W  address of dec_instr
dec_ready  in  1  decoder consumes head this cycle when dec_valid=1
redirect  in  1  branch taken; one-cycle pulse
redirect_pc  in  ADDR_W  new fetch address

Behaviour:
- Reset is asynchronous and active-high, on clock clk. Reset values: pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, dec_valid=0, dec_instr=0, dec_pc=0, FIFO count=0, state=REQ.
- FSM states:
  - REQ: mem_req=1 when count+outstanding < BUF_DEPTH; mem_addr=pc.
    - On mem_gnt: pc<=pc+1, wrapping from 2^ADDR_W-1 to 0; go to WAIT.
  - WAIT: mem_req=0. On mem_rvalid: push {pc_of_request, mem_rdata}; go to REQ.
  - DROP: mem_req=0. On mem_rvalid: discard the data; go to REQ.
- At most one outstanding request. Once asserted, mem_req and mem_addr stay stable until mem_gnt, unless a redirect occurs.
- Minimum latency: grant in cycle N, rvalid in cycle N+1, entry visible on dec_valid in cycle N+2 (FIFO output is registered). Back-to-back throughput is one instruction per 2 cycles.
- Pop: the head is removed when dec_valid&&dec_ready.
  - Push and pop in the same cycle while full is legal; count is unchanged.
  - No push is ever issued while full, because request issue is gated on space.
- dec_valid=0 when empty. dec_instr and dec_pc hold their last values when empty.
- Redirect has priority over every other event in its cycle:
  - FIFO count<=0 and dec_valid<=0 in the next cycle; pc<=redirect_pc.
  - A dec_valid&&dec_ready handshake in the same cycle counts as consumed.
  - If in WAIT, or in REQ with mem_gnt=1 that cycle: go to DROP. The outstanding response is discarded.
  - If in REQ with no grant: drop mem_req for that cycle; re-request redirect_pc from the next cycle.
  - mem_rvalid in the redirect cycle is discarded.
  - A redirect while already in DROP stays in DROP and updates pc only.
- mem_rvalid arriving in REQ (protocol error) is ignored.
- Reset mid-transaction abandons everything. The memory must also be reset.

Optional Feature:
Macro IFU_PERF_CNT_EN.
- Defined: adds output perf_starve [15:0] (cycles with dec_ready=1 and dec_valid=0) and perf_flush [15:0] (count of redirect pulses). Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and the logic are absent; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=0x0010, grant every cycle, rvalid 1 cycle after grant, dec_ready=1 -> mem_addr sequence 0x10,0x11,0x12. dec_instr matches memory, with dec_pc 0x10,0x11,0x12 in order; first dec_valid 2 cycles after first grant.
- dec_ready=0 for 10 cycles -> FIFO fills to 2, mem_req drops to 0. Releasing dec_ready drains 0x10, 0x11 in order, then fetching resumes at 0x12.
- Redirect to 0x0200 while in WAIT for 0x13 -> response for 0x13 is never presented. Next mem_addr=0x0200; first dec_pc after redirect is 0x0200.
- Redirect in the same cycle as mem_gnt for 0x05, with rvalid delayed 3 cycles -> that data is dropped. Next request is at redirect_pc; FIFO is empty in the cycle after the redirect.
- pc=0xFFFF granted -> next mem_addr=0x0000.
- Reset asserted mid-WAIT -> all outputs return to their reset values immediately. After release the first request is at RESET_PC. With IFU_PERF_CNT_EN, 5 redirects give perf_flush=5.
